// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path: digit geometry,
// active-low hex segment patterns and the all-off drive values.
package calc_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [SEG_W-1:0] HEX_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] HEX_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] HEX_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] HEX_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] HEX_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] HEX_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] HEX_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] HEX_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] HEX_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] HEX_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] HEX_A = 7'b0001000;
  localparam logic [SEG_W-1:0] HEX_B = 7'b0000011;
  localparam logic [SEG_W-1:0] HEX_C = 7'b1000110;
  localparam logic [SEG_W-1:0] HEX_D = 7'b0100001;
  localparam logic [SEG_W-1:0] HEX_E = 7'b0000110;
  localparam logic [SEG_W-1:0] HEX_F = 7'b0001110;

  localparam logic [SEG_W-1:0]  SEG_OFF = 7'h7F;
  localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/seg7_scan_display_if.sv
// Signal bundle between the result multiplexer side and the display scanner.
// Handshake: load is a one-way strobe with no ready; the scanner captures
// value on every rising clk edge where load is 1. an/seg/dp are active-low pins.
interface seg7_scan_display_if;
  import calc_pkg::*;

  logic                load;
  logic [15:0]         value;
  logic                blank_lz;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   an;
  logic [SEG_W-1:0]    seg;
  logic                dp;

  modport master (output load, value, blank_lz, dp_in, input an, seg, dp);
  modport slave  (input load, value, blank_lz, dp_in, output an, seg, dp);

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low 7-segment hex decoder.
module hex_to_seg7
  import calc_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = HEX_0;
      4'h1: seg = HEX_1;
      4'h2: seg = HEX_2;
      4'h3: seg = HEX_3;
      4'h4: seg = HEX_4;
      4'h5: seg = HEX_5;
      4'h6: seg = HEX_6;
      4'h7: seg = HEX_7;
      4'h8: seg = HEX_8;
      4'h9: seg = HEX_9;
      4'hA: seg = HEX_A;
      4'hB: seg = HEX_B;
      4'hC: seg = HEX_C;
      4'hD: seg = HEX_D;
      4'hE: seg = HEX_E;
      4'hF: seg = HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit time-multiplexed hex display driver with value capture,
// leading-zero blanking and per-digit decimal points.
module seg7_scan_display
  import calc_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_display_if.slave bus
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       val_q, val_d;
  logic [3:0]        nib;
  logic              upper_zero;
  logic              blank;
  logic [SEG_W-1:0]  hex_seg;
  logic [DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q, dp_d;

  // Outputs are decoded from next-state idx/val so a capture shows on the same edge.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == TC) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    val_d = bus.load ? bus.value : val_q;
  end

  always_comb begin
    nib        = val_d[3:0];
    upper_zero = 1'b0;
    case (idx_d)
      2'd0: begin nib = val_d[3:0];   upper_zero = 1'b0;                end
      2'd1: begin nib = val_d[7:4];   upper_zero = (val_d[15:4] == '0);  end
      2'd2: begin nib = val_d[11:8];  upper_zero = (val_d[15:8] == '0);  end
      2'd3: begin nib = val_d[15:12]; upper_zero = (val_d[15:12] == '0); end
      default: begin nib = val_d[3:0]; upper_zero = 1'b0;               end
    endcase
  end

  hex_to_seg7 u_hex (
    .nib (nib),
    .seg (hex_seg)
  );

  always_comb begin
    blank = bus.blank_lz & upper_zero;
    an_d  = ~(4'b0001 << idx_d);
    seg_d = hex_seg;
    dp_d  = ~bus.dp_in[idx_d];
    if (blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      val_q <= val_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display with DIV=4: the stimulus pushes the
// expected {an,seg,dp} per cycle, a negedge monitor pops and compares.
module tb_seg7_scan_display;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg7_scan_display_if bus ();

  seg7_scan_display #(.DIV(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b1000000; 4'h1: p = 7'b1111001; 4'h2: p = 7'b0100100; 4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001; 4'h5: p = 7'b0010010; 4'h6: p = 7'b0000010; 4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000; 4'h9: p = 7'b0010000; 4'hA: p = 7'b0001000; 4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110; 4'hD: p = 7'b0100001; 4'hE: p = 7'b0000110; default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  task automatic compare(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Monitor: one expectation per clock, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      compare(tag_q.pop_front(), {bus.an, bus.seg, bus.dp}, exp_q.pop_front());
    end
  end

  // Asynchronous reset must blank the pins without waiting for a clock edge.
  always @(posedge rst) begin
    #1;
    compare("async_rst_off", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
  end

  task automatic cyc(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    exp_q.push_back({e_an, e_seg, e_dp});
    tag_q.push_back(tag);
    @(negedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  // n cycles of digit d showing nib (or blanked); load drops after the first cycle.
  task automatic slot(input string tag, input int d, input logic [3:0] nib, input bit blank, input int n);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int i = 0; i < n; i++) begin
      e_an  = blank ? 4'hF : ~(4'b0001 << d);
      e_seg = blank ? 7'h7F : hexpat(nib);
      e_dp  = blank ? 1'b1 : ~bus.dp_in[d];
      cyc(tag, e_an, e_seg, e_dp);
    end
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.load  = 1'b1;
    bus.value = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.blank_lz = 1'b0;
    bus.dp_in    = 4'b0000;
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    cyc("reset_hold", 4'hF, 7'h7F, 1'b1);
    cyc("reset_hold", 4'hF, 7'h7F, 1'b1);

    // 1: plain scan of 1234; first slot after release is DIV-1 lit cycles.
    rst = 1'b0;
    load_val(16'h1234);
    slot("t1_d0", 0, 4'h4, 0, 3);
    slot("t1_d1", 1, 4'h3, 0, 4);
    slot("t1_d2", 2, 4'h2, 0, 4);
    slot("t1_d3", 3, 4'h1, 0, 4);
    slot("t1_wrap_d0", 0, 4'h4, 0, 4);

    // 2: leading-zero blanking, loads land on the slot-1 boundary edge.
    bus.blank_lz = 1'b1;
    load_val(16'h0042);
    slot("t2_d1", 1, 4'h4, 0, 4);
    slot("t2_d2_blank", 2, 4'h0, 1, 4);
    slot("t2_d3_blank", 3, 4'h0, 1, 4);
    slot("t2_d0", 0, 4'h2, 0, 4);
    load_val(16'h0000);
    slot("t2z_d1_blank", 1, 4'h0, 1, 4);
    slot("t2z_d2_blank", 2, 4'h0, 1, 4);
    slot("t2z_d3_blank", 3, 4'h0, 1, 4);
    slot("t2z_d0", 0, 4'h0, 0, 4);

    // 3: decimal point on digit 2 only.
    bus.blank_lz = 1'b0;
    bus.dp_in    = 4'b0100;
    load_val(16'hABCD);
    slot("t3_d1", 1, 4'hC, 0, 4);
    slot("t3_d2_dp", 2, 4'hB, 0, 4);
    slot("t3_d3", 3, 4'hA, 0, 4);
    slot("t3_d0", 0, 4'hD, 0, 4);
    bus.dp_in = 4'b0000;

    // 4: capture mid-slot shows immediately and slot timing is kept.
    load_val(16'h1111);
    slot("t4_d1_old", 1, 4'h1, 0, 2);
    load_val(16'h8888);
    slot("t4_d1_new", 1, 4'h8, 0, 2);
    slot("t4_d2", 2, 4'h8, 0, 4);
    slot("t4_d3", 3, 4'h8, 0, 4);
    slot("t4_d0", 0, 4'h8, 0, 4);

    // 6: load on the terminal-count edge uses the new value for the new digit.
    bus.blank_lz = 1'b1;
    load_val(16'h0000);
    slot("t6_pre_d1", 1, 4'h0, 1, 4);
    slot("t6_pre_d2", 2, 4'h0, 1, 4);
    slot("t6_pre_d3", 3, 4'h0, 1, 4);
    slot("t6_pre_d0", 0, 4'h0, 0, 4);
    load_val(16'hF000);
    slot("t6_d1", 1, 4'h0, 0, 4);
    slot("t6_d2", 2, 4'h0, 0, 4);
    slot("t6_d3", 3, 4'hF, 0, 4);
    slot("t6_d0", 0, 4'h0, 0, 4);

    // 5: short async reset pulse during digit 2, entirely between clock edges.
    bus.blank_lz = 1'b0;
    slot("t5_d1", 1, 4'h0, 0, 4);
    slot("t5_d2", 2, 4'h0, 0, 2);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    slot("t5_restart_d0", 0, 4'h0, 0, 3);
    slot("t5_d1_after", 1, 4'h0, 0, 4);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
